rom_burst_arbiter: RTL

- Two-requester burst read scheduler in front of the team's synchronous single-port ROM (registered data output, 1-cycle read latency).
- Each requester asks for a burst: start address plus word count. The block grants round-robin, then walks the ROM address sequentially with wrap-around.
- Returns one word per cycle to the owner, tagged with a per-requester valid and an end-of-burst pulse.
- Sits between client logic and the ROM instance; it is the ROM's only address driver.

---
 rtl/rom_burst_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/rom_burst_arbiter.sv
// rom_burst_arbiter
//
// Schedules burst reads from two requesters onto one synchronous single-port ROM
// (registered data output, one cycle read latency). A granted burst walks the ROM
// sequentially from its start address, wrapping at DEPTH-1, issuing one address per cycle.
// Returned words are tagged for their owner through a one-stage pipeline that matches
// the ROM latency.
//
// Arbitration: round-robin between simultaneous requests by default. Defining
// ROM_ARB_FIXED_PRIO_EN gives requester 0 fixed priority and removes the RR pointer.
//
// Ports:
//   clk, rst_n              clock (rising edge) and synchronous active-low reset
//   reqN_valid/addr/len     burst request from requester N (held until reqN_ack)
//   reqN_ack                one-cycle pulse: request N accepted
//   rspN_valid              rsp_data carries a word for requester N this cycle
//   rspN_done               last word of a burst for N, or a lone pulse for len=0
//   rom_addr / rom_data     ROM read address out / registered ROM data in
//   rsp_data                rom_data passed straight through
module rom_burst_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned DEPTH_LOG = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    input  logic [DEPTH_LOG-1:0] req0_addr,
    input  logic [DEPTH_LOG:0]   req0_len,
    output logic                 req0_ack,
    output logic                 rsp0_valid,
    output logic                 rsp0_done,
    input  logic                 req1_valid,
    input  logic [DEPTH_LOG-1:0] req1_addr,
    input  logic [DEPTH_LOG:0]   req1_len,
    output logic                 req1_ack,
    output logic                 rsp1_valid,
    output logic                 rsp1_done,
    output logic [DEPTH_LOG-1:0] rom_addr,
    input  logic [WIDTH-1:0]     rom_data,
    output logic [WIDTH-1:0]     rsp_data
);

    localparam logic [DEPTH_LOG-1:0] LAST_ADDR = DEPTH_LOG'(DEPTH - 1);
    localparam logic [DEPTH_LOG:0]   LEN_ONE   = (DEPTH_LOG + 1)'(1);

    typedef enum logic [1:0] {StIdle, StBurst, StDone0} state_e;

    state_e               state_q, state_d;
    logic                 owner_q;
    logic [DEPTH_LOG-1:0] addr_q;
    logic [DEPTH_LOG:0]   remain_q;
    logic [1:0]           ack_q;

    // Response pipeline, one stage to line up with the ROM's read latency
    logic                 pipe_valid_q;
    logic                 pipe_done_q;
    logic                 pipe_owner_q;

    logic                 req_any;
    logic                 grant_sel;
    logic                 prio_sel;
    logic [DEPTH_LOG-1:0] grant_addr;
    logic [DEPTH_LOG:0]   grant_len;
    logic                 last_beat;

`ifdef ROM_ARB_FIXED_PRIO_EN
    assign prio_sel = 1'b0;
`else
    logic ptr_q;

    // Pointer moves to the non-owner once a burst (or a zero-length grant) completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if ((state_q == StBurst && last_beat) || state_q == StDone0) begin
            ptr_q <= ~owner_q;
        end
    end

    assign prio_sel = ptr_q;
`endif

    // Grant selection; only consumed while idle
    always_comb begin
        req_any    = req0_valid | req1_valid;
        grant_sel  = (req0_valid && req1_valid) ? prio_sel : req1_valid;
        grant_addr = grant_sel ? req1_addr : req0_addr;
        grant_len  = grant_sel ? req1_len : req0_len;
    end

    // remain_q counts the beat currently on rom_addr, so 1 means this is the final issue
    assign last_beat = (remain_q <= LEN_ONE);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    state_d = (grant_len == '0) ? StDone0 : StBurst;
                end
            end
            StBurst: begin
                if (last_beat) begin
                    state_d = StIdle;
                end
            end
            StDone0: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Burst datapath and response pipeline
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q      <= 1'b0;
            addr_q       <= '0;
            remain_q     <= '0;
            ack_q        <= 2'b00;
            pipe_valid_q <= 1'b0;
            pipe_done_q  <= 1'b0;
            pipe_owner_q <= 1'b0;
        end else begin
            ack_q        <= 2'b00;
            pipe_valid_q <= (state_q == StBurst);
            pipe_done_q  <= (state_q == StBurst && last_beat) || (state_q == StDone0);
            pipe_owner_q <= owner_q;

            unique case (state_q)
                StIdle: begin
                    if (req_any) begin
                        owner_q  <= grant_sel;
                        remain_q <= grant_len;
                        ack_q    <= grant_sel ? 2'b10 : 2'b01;
                        // A zero-length grant issues nothing, so rom_addr keeps its value
                        if (grant_len != '0) begin
                            addr_q <= grant_addr;
                        end
                    end
                end
                StBurst: begin
                    if (last_beat) begin
                        remain_q <= '0;
                    end else begin
                        remain_q <= remain_q - LEN_ONE;
                        addr_q   <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                    end
                end
                StDone0: remain_q <= '0;
                default: remain_q <= '0;
            endcase
        end
    end

    // Outputs, all driven from registers except the data pass-through
    always_comb begin
        req0_ack   = ack_q[0];
        req1_ack   = ack_q[1];
        rsp0_valid = pipe_valid_q & ~pipe_owner_q;
        rsp1_valid = pipe_valid_q & pipe_owner_q;
        rsp0_done  = pipe_done_q & ~pipe_owner_q;
        rsp1_done  = pipe_done_q & pipe_owner_q;
        rom_addr   = addr_q;
        rsp_data   = rom_data;
    end

endmodule
